// File: rtl/clock_pkg.sv
// Shared types for the alarm clock: set-state encoding, field limits, hour helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package clock_pkg;

  typedef enum logic [2:0] {
    COUNT     = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_AHOUR = 3'd3,
    SET_AMIN  = 3'd4
  } state_t;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  // Seconds/minutes step with wrap to zero, no carry out.
  function automatic logic [5:0] wrap_inc60(input logic [5:0] v);
    return (v == MIN_MAX) ? 6'd0 : v + 6'd1;
  endfunction

  // Internal hour step with wrap 23 -> 0.
  function automatic logic [4:0] wrap_inc24(input logic [4:0] v);
    return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

  // Internal 0..23 hour to display form; 12-hour mode shows 0 and 12 as 12.
  function automatic logic [4:0] disp_hour(input logic [4:0] hr, input logic hour24);
    logic [4:0] d;
    if (hour24)
      d = hr;
    else if (hr == 5'd0 || hr == 5'd12)
      d = 5'd12;
    else if (hr > 5'd12)
      d = hr - 5'd12;
    else
      d = hr;
    return d;
  endfunction

endpackage

// File: rtl/clock_alarm_fsm_if.sv
// Button/format inputs and time/alarm display outputs of the alarm clock.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level, sampled every cycle.
interface clock_alarm_fsm_if;
  logic       mode_btn;
  logic       inc_btn;
  logic       hour24;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic [5:0] alm_minutes;
  logic [4:0] alm_hours;
  logic       alm_en;
  logic       buzz;
  logic [2:0] state;

  // Panel side: drives the buttons and format, reads the display.
  modport master (
    output mode_btn, inc_btn, hour24,
    input  seconds, minutes, hours, pm, alm_minutes, alm_hours, alm_en, buzz, state
  );

  // Clock side.
  modport slave (
    input  mode_btn, inc_btn, hour24,
    output seconds, minutes, hours, pm, alm_minutes, alm_hours, alm_en, buzz, state
  );
endinterface

// File: rtl/clock_alarm_fsm_btn_edge.sv
// Registers an active-low debounced button and pulses on each press (falling edge).
// Latency: pulse is high for one cycle, starting one clk after the button goes low.
// Backpressure: none; every falling edge yields exactly one pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  logic cur;
  logic prev;

  // Two-stage history; reset to released so no press fires out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      cur  <= btn;
      prev <= cur;
    end
  end

  assign press = prev & ~cur;
endmodule

// File: rtl/clock_alarm_fsm.sv
// Alarm clock: HH:MM:SS timekeeping, mode-driven set sequence, armed alarm with timed buzzer.
// Latency: a press acts two clk after its button goes low; hours converted combinationally.
// Backpressure: none; prescaler free-runs and buttons are sampled every cycle.
module clock_alarm_fsm
  import clock_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int ALARM_SECS   = 60,
  parameter int ALM_RST_HOUR = 6
) (
  input logic              clk,
  input logic              reset,
  clock_alarm_fsm_if.slave bus
);
  localparam int            PW            = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST    = PW'(TICK_DIV - 1);
  localparam logic [7:0]    BUZZ_LAST     = 8'(ALARM_SECS - 1);
  localparam logic [4:0]    ALM_HOUR_INIT = 5'(ALM_RST_HOUR);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    amin_q, amin_d;
  logic [4:0]    ahr_q, ahr_d;
  logic          alm_en_q, alm_en_d;
  logic          buzz_q, buzz_d;
  logic [7:0]    bcnt_q, bcnt_d;

  logic          mode_press;
  logic          inc_press;
  logic          tick;
  logic          advance;
  logic          trigger;
  logic [5:0]    nxt_sec;
  logic [5:0]    nxt_min;
  logic [4:0]    nxt_hr;

  btn_edge u_mode_edge (.clk(clk), .reset(reset), .btn(bus.mode_btn), .press(mode_press));
  btn_edge u_inc_edge  (.clk(clk), .reset(reset), .btn(bus.inc_btn),  .press(inc_press));

  // Time frozen while the time itself is being edited; alarm fires on the tick reaching alarm:00.
  assign tick    = (presc_q == PRESC_LAST);
  assign advance = tick && (state_q != SET_HOUR) && (state_q != SET_MIN);
  assign trigger = advance && alm_en_q && (nxt_sec == 6'd0) &&
                   (nxt_min == amin_q) && (nxt_hr == ahr_q);

  // Time-of-day one second on, carrying seconds -> minutes -> hours.
  always_comb begin
    nxt_sec = wrap_inc60(sec_q);
    nxt_min = min_q;
    nxt_hr  = hr_q;
    if (sec_q == SEC_MAX) begin
      nxt_min = wrap_inc60(min_q);
      if (min_q == MIN_MAX)
        nxt_hr = wrap_inc24(hr_q);
    end
  end

  // Next state plus field edits, alarm arming and buzzer control.
  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    amin_d   = amin_q;
    ahr_d    = ahr_q;
    alm_en_d = alm_en_q;
    buzz_d   = buzz_q;
    bcnt_d   = bcnt_q;

    if (advance) begin
      sec_d = nxt_sec;
      min_d = nxt_min;
      hr_d  = nxt_hr;
    end

    case (state_q)
      COUNT: begin
        // Inc silences a sounding buzzer; otherwise it arms/disarms.
        if (inc_press && !buzz_q)
          alm_en_d = ~alm_en_q;
        if (mode_press)
          state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (inc_press)
          hr_d = wrap_inc24(hr_q);
        if (mode_press)
          state_d = SET_MIN;
      end
      SET_MIN: begin
        if (inc_press)
          min_d = wrap_inc60(min_q);
        // Restart the second cleanly once the time has been set.
        if (mode_press) begin
          state_d = SET_AHOUR;
          sec_d   = 6'd0;
          presc_d = '0;
        end
      end
      SET_AHOUR: begin
        if (inc_press)
          ahr_d = wrap_inc24(ahr_q);
        if (mode_press)
          state_d = SET_AMIN;
      end
      SET_AMIN: begin
        if (inc_press)
          amin_d = wrap_inc60(amin_q);
        if (mode_press)
          state_d = COUNT;
      end
      default: state_d = COUNT;
    endcase

    // Any press wins over a trigger in the same cycle, so a disarming press never buzzes.
    if (inc_press || mode_press) begin
      buzz_d = 1'b0;
    end else if (trigger) begin
      buzz_d = 1'b1;
      bcnt_d = 8'd0;
    end else if (buzz_q && tick) begin
      if (bcnt_q == BUZZ_LAST)
        buzz_d = 1'b0;
      else
        bcnt_d = bcnt_q + 8'd1;
    end
    if (!alm_en_d)
      buzz_d = 1'b0;
  end

  // Set-state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= COUNT;
    else
      state_q <= state_d;
  end

  // Time, alarm and buzzer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      sec_q    <= 6'd0;
      min_q    <= 6'd0;
      hr_q     <= 5'd0;
      amin_q   <= 6'd0;
      ahr_q    <= ALM_HOUR_INIT;
      alm_en_q <= 1'b0;
      buzz_q   <= 1'b0;
      bcnt_q   <= 8'd0;
    end else begin
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
      amin_q   <= amin_d;
      ahr_q    <= ahr_d;
      alm_en_q <= alm_en_d;
      buzz_q   <= buzz_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign bus.seconds     = sec_q;
  assign bus.minutes     = min_q;
  assign bus.hours       = disp_hour(hr_q, bus.hour24);
  assign bus.pm          = (hr_q >= 5'd12);
  assign bus.alm_minutes = amin_q;
  assign bus.alm_hours   = disp_hour(ahr_q, bus.hour24);
  assign bus.alm_en      = alm_en_q;
  assign bus.buzz        = buzz_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_clock_alarm_fsm.sv
// Bench for clock_alarm_fsm with a 4-cycle tick and 3-second buzzer.
// Latency: expectations are queued with each stimulus step and drained at the following negedge.
// Backpressure: n/a.
module tb_clock_alarm_fsm;
  localparam int TICK_DIV     = 4;
  localparam int ALARM_SECS   = 3;
  localparam int ALM_RST_HOUR = 6;

  localparam int O_SEC   = 0;
  localparam int O_MIN   = 1;
  localparam int O_HR    = 2;
  localparam int O_PM    = 3;
  localparam int O_AMIN  = 4;
  localparam int O_AHR   = 5;
  localparam int O_EN    = 6;
  localparam int O_BUZZ  = 7;
  localparam int O_STATE = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  clock_alarm_fsm_if dut_if ();

  clock_alarm_fsm #(
    .TICK_DIV    (TICK_DIV),
    .ALARM_SECS  (ALARM_SECS),
    .ALM_RST_HOUR(ALM_RST_HOUR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      O_SEC:   return 32'(dut_if.seconds);
      O_MIN:   return 32'(dut_if.minutes);
      O_HR:    return 32'(dut_if.hours);
      O_PM:    return 32'(dut_if.pm);
      O_AMIN:  return 32'(dut_if.alm_minutes);
      O_AHR:   return 32'(dut_if.alm_hours);
      O_EN:    return 32'(dut_if.alm_en);
      O_BUZZ:  return 32'(dut_if.buzz);
      O_STATE: return 32'(dut_if.state);
      default: return 32'hffff_ffff;
    endcase
  endfunction

  task automatic exp_push(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Reset values as seen with hour24=0.
  task automatic exp_reset(input string pfx);
    exp_push({pfx, "_sec"},   O_SEC,   0);
    exp_push({pfx, "_min"},   O_MIN,   0);
    exp_push({pfx, "_hr"},    O_HR,    12);
    exp_push({pfx, "_pm"},    O_PM,    0);
    exp_push({pfx, "_amin"},  O_AMIN,  0);
    exp_push({pfx, "_ahr"},   O_AHR,   ALM_RST_HOUR);
    exp_push({pfx, "_en"},    O_EN,    0);
    exp_push({pfx, "_buzz"},  O_BUZZ,  0);
    exp_push({pfx, "_state"}, O_STATE, 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge right after the posedge where the press takes effect.
  task automatic press(input bit is_inc, input int times);
    repeat (times) begin
      @(negedge clk);
      if (is_inc) dut_if.inc_btn = 1'b0;
      else        dut_if.mode_btn = 1'b0;
      @(negedge clk);
      dut_if.inc_btn  = 1'b1;
      dut_if.mode_btn = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset(input logic fmt24);
    @(negedge clk);
    dut_if.hour24 = fmt24;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset           = 1'b1;
    dut_if.mode_btn = 1'b1;
    dut_if.inc_btn  = 1'b1;
    dut_if.hour24   = 1'b0;
    #3 reset = 1'b0;

    // Reset values, 12-hour display of hour 0 is 12.
    exp_reset("rst");
    step(2);
    drain();

    // Tick every 4 cycles: second 3 completes on the 12th edge after release.
    @(negedge clk);
    reset = 1'b1;
    exp_push("sec_at_11", O_SEC, 2);
    step(11);
    drain();
    exp_push("sec_at_12", O_SEC, 3);
    step(1);
    drain();
    exp_push("sec_at_15", O_SEC, 3);
    step(3);
    drain();
    exp_push("sec_at_16", O_SEC, 4);
    step(1);
    drain();

    // Set hour 5, then minutes 2; leaving SET_MIN clears seconds.
    apply_reset(1'b1);
    press(0, 1);
    exp_push("set_hr_state", O_STATE, 1);
    drain();
    press(1, 5);
    exp_push("set_hr_val", O_HR, 5);
    drain();
    press(0, 1);
    press(1, 2);
    press(0, 1);
    exp_push("set_min_val",   O_MIN,   2);
    exp_push("set_min_sec",   O_SEC,   0);
    exp_push("set_min_state", O_STATE, 3);
    exp_push("set_min_hr",    O_HR,    5);
    drain();

    // 23:59:59 -> 12:00:00 am in 12-hour mode.
    apply_reset(1'b0);
    press(0, 1);
    press(1, 23);
    press(0, 1);
    press(1, 59);
    press(0, 1);
    press(0, 2);
    step(233);
    exp_push("pre_2359_hr",  O_HR,  11);
    exp_push("pre_2359_pm",  O_PM,  1);
    exp_push("pre_2359_min", O_MIN, 59);
    exp_push("pre_2359_sec", O_SEC, 59);
    drain();
    step(1);
    exp_push("roll_0000_hr",  O_HR,  12);
    exp_push("roll_0000_pm",  O_PM,  0);
    exp_push("roll_0000_min", O_MIN, 0);
    exp_push("roll_0000_sec", O_SEC, 0);
    drain();

    // 11:59:59 -> 12:00:00 pm.
    press(0, 1);
    press(1, 11);
    press(0, 1);
    press(1, 59);
    press(0, 1);
    press(0, 2);
    step(233);
    exp_push("pre_1159_hr", O_HR, 11);
    exp_push("pre_1159_pm", O_PM, 0);
    drain();
    step(1);
    exp_push("roll_1200_hr",  O_HR,  12);
    exp_push("roll_1200_pm",  O_PM,  1);
    exp_push("roll_1200_min", O_MIN, 0);
    drain();

    // Alarm 0:01 armed: buzz rises at 00:01:00 and lasts 3 ticks.
    apply_reset(1'b1);
    press(0, 3);
    exp_push("ahr_state", O_STATE, 3);
    exp_push("ahr_init",  O_AHR,   ALM_RST_HOUR);
    drain();
    press(1, 18);
    exp_push("ahr_wrap", O_AHR, 0);
    drain();
    press(0, 1);
    press(1, 1);
    exp_push("amin_set", O_AMIN, 1);
    drain();
    press(0, 1);
    press(1, 1);
    exp_push("arm_en", O_EN, 1);
    drain();
    step(173);
    exp_push("alm_pre_buzz", O_BUZZ, 0);
    exp_push("alm_pre_sec",  O_SEC,  59);
    drain();
    step(1);
    exp_push("alm_rise_buzz", O_BUZZ, 1);
    exp_push("alm_rise_min",  O_MIN,  1);
    exp_push("alm_rise_sec",  O_SEC,  0);
    drain();
    step(11);
    exp_push("alm_hold_buzz", O_BUZZ, 1);
    drain();
    step(1);
    exp_push("alm_fall_buzz", O_BUZZ, 0);
    exp_push("alm_fall_en",   O_EN,   1);
    drain();

    // Disarming press lands on the same cycle as the 00:02:00 trigger tick.
    press(0, 3);
    press(0, 1);
    press(1, 1);
    press(0, 1);
    exp_push("race_amin",  O_AMIN,  2);
    exp_push("race_state", O_STATE, 0);
    drain();
    step(228);
    press(1, 1);
    exp_push("race_en",   O_EN,   0);
    exp_push("race_buzz", O_BUZZ, 0);
    exp_push("race_min",  O_MIN,  2);
    exp_push("race_sec",  O_SEC,  0);
    drain();
    step(4);
    exp_push("race_buzz_late", O_BUZZ, 0);
    drain();

    // Asynchronous reset in the middle of SET_MIN.
    apply_reset(1'b0);
    press(0, 2);
    press(1, 3);
    exp_push("mid_state", O_STATE, 2);
    exp_push("mid_min",   O_MIN,   3);
    drain();
    #2 reset = 1'b0;
    #1;
    exp_reset("async");
    drain();
    step(1);
    reset = 1'b1;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_alarm_fsm.md
CLOCK_ALARM_FSM -- requirements
Module: clock_alarm_fsm

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clk cycles per second tick (>=2).
REQ-002 Parameter ALARM_SECS, default 60, seconds the buzzer stays on unless silenced (1..255).
REQ-003 Parameter ALM_RST_HOUR, default 6, alarm hour after reset (0..23, internal form).
REQ-004 Port clk input 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset input 1: asynchronous, active-low reset.
REQ-006 Port mode_btn input 1: active-low pushbutton (already debounced); advances the set state machine.
REQ-007 Port inc_btn input 1: active-low pushbutton (already debounced); increments the selected field, or toggles alarm enable in COUNT.
REQ-008 Port hour24 input 1: display format, 1 = 24-hour, 0 = 12-hour; may change at any time.
REQ-009 Port seconds output 6: current seconds, 0..59.
REQ-010 Port minutes output 6: current minutes, 0..59.
REQ-011 Port hours output 5: current display hour, 0..23 or 1..12.
REQ-012 Port pm output 1: 1 when the internal hour is 12..23, regardless of hour24.
REQ-013 Port alm_minutes output 6, and alm_hours output 5: alarm setting, same display form as the time outputs.
REQ-014 Port alm_en output 1: alarm armed.
REQ-015 Port buzz output 1: alarm sounding.
REQ-016 Port state output 3: current set-state encoding, for display blanking/blink.

Function
REQ-017 A prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on the terminal count; its width is the ceiling of log2(TICK_DIV).
REQ-018 Time and alarm hours SHALL be held internally as 0..23.
REQ-019 Display hours SHALL be the internal value when hour24=1; otherwise internal 0 and 12 display as 12, and other values as internal mod 12; the conversion is combinational.
REQ-020 Button presses SHALL be the falling edges of the registered button inputs; each edge produces exactly one press pulse.
REQ-021 States: COUNT, SET_HOUR, SET_MIN, SET_AHOUR, SET_AMIN.
REQ-022 A mode press SHALL advance COUNT->SET_HOUR->SET_MIN->SET_AHOUR->SET_AMIN->COUNT.
REQ-023 COUNT: each tick SHALL increment seconds, with 59->0 carrying to minutes, minutes 59->0 carrying to hours, and hours 23->0.
REQ-024 COUNT: an inc press SHALL toggle alm_en; if buzz is active, it SHALL instead clear buzz and leave alm_en unchanged.
REQ-025 SET_HOUR/SET_MIN: ticks are ignored (time frozen); an inc press increments the field modulo 24 or 60 without carry.
REQ-026 Leaving SET_MIN SHALL clear seconds and the prescaler.
REQ-027 SET_AHOUR/SET_AMIN: time keeps counting; an inc press increments the alarm field modulo 24 or 60.
REQ-028 Alarm trigger: in COUNT or an alarm-set state, with alm_en=1, buzz SHALL be set on the tick that makes the time equal alarm:00.
REQ-029 buzz SHALL clear after ALARM_SECS ticks, on any press, or when alm_en is cleared.
REQ-030 A tick and a press in the same cycle SHALL both take effect; a press that toggles alm_en wins over a simultaneous alarm trigger.
REQ-031 A mode press and a tick in the same cycle while in SET_MIN: the tick is ignored, then seconds are cleared.

Reset
REQ-032 While reset=0: state=COUNT, prescaler=0, seconds=0, minutes=0, internal hour=0 (display 12 with pm=0 in 12-hour mode), alarm=ALM_RST_HOUR:00, alm_en=0, buzz=0, button history=released.
REQ-033 Reset asserted mid-set or mid-alarm SHALL abort immediately to the reset values, with no partial increment.

Structure
REQ-034 Package clock_pkg SHALL hold the state encodings, the field limits (59, 23) and the hour-conversion function.
REQ-035 One sub-module, btn_edge (register plus falling-edge pulse), SHALL be instantiated once per button.

Verification
REQ-036 With TICK_DIV=4, release reset and run 3 ticks -> seconds=3 and tick period = 4 clk cycles.
REQ-037 Preload 23:59:59 with hour24=0 and apply 1 tick -> display 12:00:00, pm=0; with 11:59:59 -> 12:00:00, pm=1.
REQ-038 Press mode once and inc 5 times from reset -> internal hour 5; press mode, inc 2, press mode -> minutes=2, seconds=0, state=SET_AHOUR.
REQ-039 Set alarm 0:01 with alm_en=1 and run to 00:01:00 -> buzz rises on that tick; with ALARM_SECS=3 it falls 3 ticks later.
REQ-040 Drive inc press and alarm tick in the same cycle with buzz=0 -> alm_en=0 and buzz stays 0.
REQ-041 Assert reset mid-SET_MIN -> all outputs at REQ-032 values within the same cycle, asynchronously.
